// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory.
// Optional build macro MEM_ARB_RR_EN: alternating grant on contention instead of data-first priority.
module mem_arbiter #(
    parameter int AW   = 30,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          halt_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_valid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_valid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            owner_q, owner_d;   // 1 = data port owns the transaction
    logic            last_q, last_d;     // 1 = data port was granted last
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

    logic            idle_s, fetch_elig_s, data_elig_s, pick_data_s;
    logic            gnt_f_s, gnt_d_s, gnt_any_s;

    // Grant selection, only while idle and out of reset
    always_comb begin
        idle_s       = (state_q == S_IDLE) && rst_ni;
        fetch_elig_s = if_req_i && !halt_i;
        data_elig_s  = d_req_i;
`ifdef MEM_ARB_RR_EN
        pick_data_s  = data_elig_s && (!fetch_elig_s || !last_q);
`else
        pick_data_s  = data_elig_s;
`endif
        gnt_d_s      = idle_s && pick_data_s;
        gnt_f_s      = idle_s && fetch_elig_s && !pick_data_s;
        gnt_any_s    = gnt_d_s || gnt_f_s;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = gnt_any_s ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = (cnt_q == LAST_CNT) ? S_RESP : S_ACCESS;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch the winner's request, count access cycles, capture read data
    always_comb begin
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (gnt_any_s) begin
            cnt_d   = 4'd0;
            owner_d = gnt_d_s;
            last_d  = gnt_d_s;
            we_d    = gnt_d_s && d_we_i;
            addr_d  = gnt_d_s ? d_addr_i : if_addr_i;
            wdata_d = gnt_d_s ? d_wdata_i : '0;
        end else if (state_q == S_ACCESS) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q == LAST_CNT) && !we_q) begin
                if (owner_q) begin
                    d_rdata_d = mem_rdata_i;
                end else begin
                    if_rdata_d = mem_rdata_i;
                end
            end else begin
                d_rdata_d = d_rdata_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 4'd0;
            owner_q    <= 1'b1;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Outputs decoded from state; memory bus is quiet outside ACCESS
    always_comb begin
        if_gnt_o    = gnt_f_s;
        d_gnt_o     = gnt_d_s;
        busy_o      = (state_q != S_IDLE);
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_valid_o  = 1'b0;
        d_valid_o   = 1'b0;
        if (state_q == S_ACCESS) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
        end else if (state_q == S_RESP) begin
            if_valid_o = !owner_q;
            d_valid_o  = owner_q;
        end else begin
            mem_en_o = 1'b0;
        end
        if_rdata_o = if_rdata_q;
        d_rdata_o  = d_rdata_q;
    end

endmodule
